// File: rtl/wb_stage_tlbx.sv
// rtl/wb_stage_tlbx.sv - writeback stage with multi-cycle TLBWI/TLBR sequencing
//
// Retires MEM-stage instructions: writes the regfile, drives the CP0
// register file interface and runs TLBWI/TLBR against a TLB that needs
// TLB_LAT cycles after issue. While a TLB op is in flight the stage holds
// ws_allowin low; on completion it pulses start_refetch for one cycle.
//
// Parameters:
//   TLBNUM   number of TLB entries
//   IDXW     TLB index width, clog2(TLBNUM)
//   TLB_LAT  cycles from issue to completion of a TLB op (1..15)
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   ms_to_ws_valid, ws_allowin  MEM->WB handshake
//   ms_*                     instruction payload from MEM
//   rf_we/rf_waddr/rf_wdata  regfile write port
//   c0_*                     CP0 register file interface
//   tlb_we, tlb_index        TLB write strobe / index
//   ws_flush                 pipeline flush (exception or eret)
//   start_refetch            refetch from ws_pc+4 after a TLB op
//   debug_wb_*               retirement trace

module wb_stage_tlbx #(
    parameter int TLBNUM  = 16,
    parameter int IDXW    = 4,
    parameter int TLB_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ms_to_ws_valid,
    output logic            ws_allowin,
    input  logic [31:0]     ms_pc,
    input  logic [31:0]     ms_result,
    input  logic [4:0]      ms_dest,
    input  logic [3:0]      ms_rf_we,
    input  logic            ms_ex,
    input  logic [4:0]      ms_excode,
    input  logic            ms_bd,
    input  logic [31:0]     ms_badvaddr,
    input  logic [2:0]      ms_op,
    input  logic [7:0]      ms_c0_addr,
    output logic [3:0]      rf_we,
    output logic [4:0]      rf_waddr,
    output logic [31:0]     rf_wdata,
    input  logic [31:0]     c0_rdata,
    output logic [7:0]      c0_addr,
    output logic [31:0]     c0_wdata,
    output logic            c0_mtc0_we,
    output logic            c0_ex,
    output logic [4:0]      c0_excode,
    output logic            c0_bd,
    output logic [31:0]     c0_pc,
    output logic [31:0]     c0_badvaddr,
    output logic            c0_eret,
    output logic            c0_tlbr_load,
    input  logic [IDXW-1:0] c0_index,
    output logic            tlb_we,
    output logic [IDXW-1:0] tlb_index,
    output logic            ws_flush,
    output logic            start_refetch,
    output logic [31:0]     debug_wb_pc,
    output logic [3:0]      debug_wb_rf_wen,
    output logic [4:0]      debug_wb_rf_wnum,
    output logic [31:0]     debug_wb_rf_wdata
);

    localparam logic [2:0] OP_MTC0  = 3'd1;
    localparam logic [2:0] OP_MFC0  = 3'd2;
    localparam logic [2:0] OP_ERET  = 3'd3;
    localparam logic [2:0] OP_TLBWI = 3'd4;
    localparam logic [2:0] OP_TLBR  = 3'd5;
    localparam logic [3:0] LAT      = 4'(TLB_LAT);

    // Configuration guard: the index port must address exactly TLBNUM entries.
    if ((1 << IDXW) < TLBNUM || (1 << (IDXW - 1)) >= TLBNUM) begin : g_bad_cfg
        $error("wb_stage_tlbx: IDXW must equal clog2(TLBNUM)");
    end

    logic        ws_valid;
    logic [31:0] ws_pc;
    logic [31:0] ws_result;
    logic [4:0]  ws_dest;
    logic [3:0]  ws_rf_we;
    logic        ws_ex_flag;
    logic [4:0]  ws_excode;
    logic        ws_bd;
    logic [31:0] ws_badvaddr;
    logic [2:0]  ws_op;
    logic [7:0]  ws_c0_addr;

    logic [3:0]  cnt;
    logic [3:0]  cnt_next;

    logic        ws_ex;
    logic        ws_ready_go;
    logic        tlbop;
    logic        tlb_issue;
    logic        tlb_done;

    // Pipeline valid and payload
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid <= 1'b0;
        end else if (ws_flush) begin
            ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            ws_valid <= ms_to_ws_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_pc       <= 32'd0;
            ws_result   <= 32'd0;
            ws_dest     <= 5'd0;
            ws_rf_we    <= 4'd0;
            ws_ex_flag  <= 1'b0;
            ws_excode   <= 5'd0;
            ws_bd       <= 1'b0;
            ws_badvaddr <= 32'd0;
            ws_op       <= 3'd0;
            ws_c0_addr  <= 8'd0;
        end else if (ms_to_ws_valid && ws_allowin) begin
            ws_pc       <= ms_pc;
            ws_result   <= ms_result;
            ws_dest     <= ms_dest;
            ws_rf_we    <= ms_rf_we;
            ws_ex_flag  <= ms_ex;
            ws_excode   <= ms_excode;
            ws_bd       <= ms_bd;
            ws_badvaddr <= ms_badvaddr;
            ws_op       <= ms_op;
            ws_c0_addr  <= ms_c0_addr;
        end
    end

    assign ws_ex    = ws_valid && ws_ex_flag;
    assign ws_flush = ws_ex || (ws_valid && ws_op == OP_ERET);
    assign tlbop    = ws_valid && !ws_ex && (ws_op == OP_TLBWI || ws_op == OP_TLBR);

    // TLB op sequencer. The state is the counter itself:
    // cnt==0 ISSUE, 0<cnt<LAT WAIT, cnt==LAT DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else begin
            cnt <= cnt_next;
        end
    end

    // ws_allowin is low only during ISSUE/WAIT, so clearing on ws_allowin
    // covers both "instruction leaves" and "new instruction captured".
    always_comb begin
        cnt_next = cnt;
        if (ws_flush || ws_allowin) begin
            cnt_next = 4'd0;
        end else if (tlbop && cnt != LAT) begin
            cnt_next = 4'(cnt + 4'd1);
        end
    end

    always_comb begin
        tlb_issue     = tlbop && (cnt == 4'd0);
        tlb_done      = tlbop && (cnt == LAT);
        tlb_we        = tlb_issue && (ws_op == OP_TLBWI);
        ws_ready_go   = !tlbop || tlb_done;
        start_refetch = tlb_done;
        c0_tlbr_load  = tlb_done && (ws_op == OP_TLBR);
    end

    // The index is held for the whole op so the TLB read port stays stable
    // until CP0 latches its data in DONE.
    assign tlb_index  = tlbop ? c0_index : '0;

    assign ws_allowin = !ws_valid || ws_ready_go;

    // Regfile write
    assign rf_we    = ws_rf_we & {4{ws_valid && !ws_ex}};
    assign rf_waddr = ws_dest;
    assign rf_wdata = (ws_op == OP_MFC0) ? c0_rdata : ws_result;

    assign debug_wb_pc       = ws_pc;
    assign debug_wb_rf_wen   = rf_we;
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    // CP0 interface
    assign c0_addr     = ws_c0_addr;
    assign c0_wdata    = ws_result;
    assign c0_mtc0_we  = ws_valid && (ws_op == OP_MTC0) && !ws_ex;
    assign c0_ex       = ws_ex;
    assign c0_excode   = ws_ex ? ws_excode : 5'd0;
    assign c0_bd       = ws_ex && ws_bd;
    assign c0_badvaddr = ws_ex ? ws_badvaddr : 32'd0;
    assign c0_pc       = ws_pc;
    // An excepting eret is reported as an exception only.
    assign c0_eret     = ws_valid && (ws_op == OP_ERET) && !ws_ex;

endmodule

// File: tb/tb_wb_stage_tlbx.sv
// tb/tb_wb_stage_tlbx.sv - directed self-checking bench for wb_stage_tlbx

module tb_wb_stage_tlbx;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc, ms_result, ms_badvaddr, c0_rdata;
    logic [4:0]  ms_dest, ms_excode;
    logic [3:0]  ms_rf_we;
    logic        ms_ex, ms_bd;
    logic [2:0]  ms_op;
    logic [7:0]  ms_c0_addr;
    logic [3:0]  c0_index;

    // Instance a: TLB_LAT=3
    logic        a_allowin, a_mtc0_we, a_ex, a_bd, a_eret, a_tlbr_load, a_tlb_we, a_flush, a_refetch;
    logic [3:0]  a_rf_we, a_dbg_wen, a_tlb_index;
    logic [4:0]  a_rf_waddr, a_excode, a_dbg_wnum;
    logic [31:0] a_rf_wdata, a_wdata, a_pc, a_badvaddr, a_dbg_pc, a_dbg_wdata;
    logic [7:0]  a_c0_addr;

    // Instance b: TLB_LAT=4
    logic        b_allowin, b_mtc0_we, b_ex, b_bd, b_eret, b_tlbr_load, b_tlb_we, b_flush, b_refetch;
    logic [3:0]  b_rf_we, b_dbg_wen, b_tlb_index;
    logic [4:0]  b_rf_waddr, b_excode, b_dbg_wnum;
    logic [31:0] b_rf_wdata, b_wdata, b_pc, b_badvaddr, b_dbg_pc, b_dbg_wdata;
    logic [7:0]  b_c0_addr;

    int checks = 0;
    int errors = 0;

    wb_stage_tlbx #(.TLBNUM(16), .IDXW(4), .TLB_LAT(3)) u_dut_a (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(a_allowin),
        .ms_pc(ms_pc), .ms_result(ms_result), .ms_dest(ms_dest), .ms_rf_we(ms_rf_we),
        .ms_ex(ms_ex), .ms_excode(ms_excode), .ms_bd(ms_bd), .ms_badvaddr(ms_badvaddr),
        .ms_op(ms_op), .ms_c0_addr(ms_c0_addr),
        .rf_we(a_rf_we), .rf_waddr(a_rf_waddr), .rf_wdata(a_rf_wdata),
        .c0_rdata(c0_rdata), .c0_addr(a_c0_addr), .c0_wdata(a_wdata), .c0_mtc0_we(a_mtc0_we),
        .c0_ex(a_ex), .c0_excode(a_excode), .c0_bd(a_bd), .c0_pc(a_pc),
        .c0_badvaddr(a_badvaddr), .c0_eret(a_eret), .c0_tlbr_load(a_tlbr_load),
        .c0_index(c0_index), .tlb_we(a_tlb_we), .tlb_index(a_tlb_index),
        .ws_flush(a_flush), .start_refetch(a_refetch),
        .debug_wb_pc(a_dbg_pc), .debug_wb_rf_wen(a_dbg_wen),
        .debug_wb_rf_wnum(a_dbg_wnum), .debug_wb_rf_wdata(a_dbg_wdata)
    );

    wb_stage_tlbx #(.TLBNUM(16), .IDXW(4), .TLB_LAT(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(b_allowin),
        .ms_pc(ms_pc), .ms_result(ms_result), .ms_dest(ms_dest), .ms_rf_we(ms_rf_we),
        .ms_ex(ms_ex), .ms_excode(ms_excode), .ms_bd(ms_bd), .ms_badvaddr(ms_badvaddr),
        .ms_op(ms_op), .ms_c0_addr(ms_c0_addr),
        .rf_we(b_rf_we), .rf_waddr(b_rf_waddr), .rf_wdata(b_rf_wdata),
        .c0_rdata(c0_rdata), .c0_addr(b_c0_addr), .c0_wdata(b_wdata), .c0_mtc0_we(b_mtc0_we),
        .c0_ex(b_ex), .c0_excode(b_excode), .c0_bd(b_bd), .c0_pc(b_pc),
        .c0_badvaddr(b_badvaddr), .c0_eret(b_eret), .c0_tlbr_load(b_tlbr_load),
        .c0_index(c0_index), .tlb_we(b_tlb_we), .tlb_index(b_tlb_index),
        .ws_flush(b_flush), .start_refetch(b_refetch),
        .debug_wb_pc(b_dbg_pc), .debug_wb_rf_wen(b_dbg_wen),
        .debug_wb_rf_wnum(b_dbg_wnum), .debug_wb_rf_wdata(b_dbg_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        ms_to_ws_valid = 1'b0;
        ms_pc          = 32'd0;
        ms_result      = 32'd0;
        ms_dest        = 5'd0;
        ms_rf_we       = 4'd0;
        ms_ex          = 1'b0;
        ms_excode      = 5'd0;
        ms_bd          = 1'b0;
        ms_badvaddr    = 32'd0;
        ms_op          = 3'd0;
        ms_c0_addr     = 8'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        reset    = 1'b1;
        c0_rdata = 32'hDEADBEEF;
        c0_index = 4'd0;
        clear_inputs();
        idle(3);

        // Reset state
        check("rst_rf_we", {28'd0, a_rf_we}, 32'd0);
        check("rst_c0_pc", a_pc, 32'd0);
        check("rst_tlb_we", {31'd0, a_tlb_we}, 32'd0);
        check("rst_refetch", {31'd0, a_refetch}, 32'd0);
        check("rst_allowin", {31'd0, a_allowin}, 32'd1);

        // Plain ALU retire
        reset          = 1'b0;
        ms_to_ws_valid = 1'b1;
        ms_pc          = 32'hBFC00010;
        ms_dest        = 5'd5;
        ms_result      = 32'h00001234;
        ms_rf_we       = 4'hF;
        @(negedge clk);
        clear_inputs();
        check("alu_rf_we", {28'd0, a_rf_we}, 32'hF);
        check("alu_waddr", {27'd0, a_rf_waddr}, 32'd5);
        check("alu_wdata", a_rf_wdata, 32'h00001234);
        check("alu_allowin", {31'd0, a_allowin}, 32'd1);
        check("alu_dbg_pc", a_dbg_pc, 32'hBFC00010);
        check("alu_dbg_wen", {28'd0, a_dbg_wen}, 32'hF);
        @(negedge clk);
        check("bubble_rf_we", {28'd0, a_rf_we}, 32'd0);

        // MFC0
        ms_to_ws_valid = 1'b1;
        ms_op          = 3'd2;
        ms_c0_addr     = 8'h60;
        ms_dest        = 5'd8;
        ms_result      = 32'h00000055;
        ms_rf_we       = 4'hF;
        @(negedge clk);
        clear_inputs();
        check("mfc0_wdata", a_rf_wdata, 32'hDEADBEEF);
        check("mfc0_c0_addr", {24'd0, a_c0_addr}, 32'h60);
        check("mfc0_mtc0_we", {31'd0, a_mtc0_we}, 32'd0);

        // MTC0
        ms_to_ws_valid = 1'b1;
        ms_op          = 3'd1;
        ms_c0_addr     = 8'h58;
        ms_result      = 32'h0000CAFE;
        @(negedge clk);
        clear_inputs();
        check("mtc0_we", {31'd0, a_mtc0_we}, 32'd1);
        check("mtc0_wdata", a_wdata, 32'h0000CAFE);
        check("mtc0_rf_we", {28'd0, a_rf_we}, 32'd0);
        idle(1);

        // TLBWI on the TLB_LAT=3 instance
        ms_to_ws_valid = 1'b1;
        ms_op          = 3'd4;
        ms_pc          = 32'hBFC00100;
        c0_index       = 4'd7;
        @(negedge clk);
        clear_inputs();
        check("tlbwi_c1_we", {31'd0, a_tlb_we}, 32'd1);
        check("tlbwi_c1_idx", {28'd0, a_tlb_index}, 32'd7);
        check("tlbwi_c1_allowin", {31'd0, a_allowin}, 32'd0);
        check("tlbwi_c1_refetch", {31'd0, a_refetch}, 32'd0);
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            check("tlbwi_wait_we", {31'd0, a_tlb_we}, 32'd0);
            check("tlbwi_wait_allowin", {31'd0, a_allowin}, 32'd0);
            check("tlbwi_wait_refetch", {31'd0, a_refetch}, 32'd0);
        end
        @(negedge clk);
        check("tlbwi_c4_refetch", {31'd0, a_refetch}, 32'd1);
        check("tlbwi_c4_allowin", {31'd0, a_allowin}, 32'd1);
        check("tlbwi_c4_we", {31'd0, a_tlb_we}, 32'd0);
        check("tlbwi_c4_tlbr_load", {31'd0, a_tlbr_load}, 32'd0);
        @(negedge clk);
        check("tlbwi_c5_refetch", {31'd0, a_refetch}, 32'd0);
        check("tlbwi_c5_we", {31'd0, a_tlb_we}, 32'd0);
        idle(3);

        // TLBR without exception: loads CP0 in DONE, never writes the TLB
        ms_to_ws_valid = 1'b1;
        ms_op          = 3'd5;
        c0_index       = 4'd3;
        @(negedge clk);
        clear_inputs();
        check("tlbr_c1_we", {31'd0, a_tlb_we}, 32'd0);
        check("tlbr_c1_load", {31'd0, a_tlbr_load}, 32'd0);
        idle(2);
        check("tlbr_c3_allowin", {31'd0, a_allowin}, 32'd0);
        @(negedge clk);
        check("tlbr_c4_load", {31'd0, a_tlbr_load}, 32'd1);
        check("tlbr_c4_refetch", {31'd0, a_refetch}, 32'd1);
        check("tlbr_c4_idx", {28'd0, a_tlb_index}, 32'd3);
        idle(3);

        // TLBR with upstream exception
        ms_to_ws_valid = 1'b1;
        ms_op          = 3'd5;
        ms_ex          = 1'b1;
        ms_excode      = 5'h0A;
        ms_bd          = 1'b1;
        ms_badvaddr    = 32'h00001000;
        ms_rf_we       = 4'hF;
        @(negedge clk);
        clear_inputs();
        check("ex_c0_ex", {31'd0, a_ex}, 32'd1);
        check("ex_excode", {27'd0, a_excode}, 32'h0A);
        check("ex_bd", {31'd0, a_bd}, 32'd1);
        check("ex_badvaddr", a_badvaddr, 32'h00001000);
        check("ex_flush", {31'd0, a_flush}, 32'd1);
        check("ex_tlb_we", {31'd0, a_tlb_we}, 32'd0);
        check("ex_tlbr_load", {31'd0, a_tlbr_load}, 32'd0);
        check("ex_refetch", {31'd0, a_refetch}, 32'd0);
        check("ex_allowin", {31'd0, a_allowin}, 32'd1);
        check("ex_rf_we", {28'd0, a_rf_we}, 32'd0);
        @(negedge clk);
        check("ex_next_c0_ex", {31'd0, a_ex}, 32'd0);
        check("ex_next_excode", {27'd0, a_excode}, 32'd0);
        check("ex_next_refetch", {31'd0, a_refetch}, 32'd0);
        idle(1);

        // ERET followed by a valid instruction in MEM
        ms_to_ws_valid = 1'b1;
        ms_op          = 3'd3;
        @(negedge clk);
        clear_inputs();
        ms_to_ws_valid = 1'b1;
        ms_dest        = 5'd3;
        ms_result      = 32'h0000BEEF;
        ms_rf_we       = 4'hF;
        check("eret_c0_eret", {31'd0, a_eret}, 32'd1);
        check("eret_flush", {31'd0, a_flush}, 32'd1);
        check("eret_c0_ex", {31'd0, a_ex}, 32'd0);
        @(negedge clk);
        clear_inputs();
        check("eret_next_rf_we", {28'd0, a_rf_we}, 32'd0);
        check("eret_next_dbg_wen", {28'd0, a_dbg_wen}, 32'd0);
        check("eret_next_eret", {31'd0, a_eret}, 32'd0);
        check("eret_next_flush", {31'd0, a_flush}, 32'd0);
        idle(2);

        // Reset mid-WAIT on the TLB_LAT=4 instance
        ms_to_ws_valid = 1'b1;
        ms_op          = 3'd4;
        ms_pc          = 32'hBFC00200;
        c0_index       = 4'd9;
        @(negedge clk);
        clear_inputs();
        check("rstw_c1_we", {31'd0, b_tlb_we}, 32'd1);
        check("rstw_c1_idx", {28'd0, b_tlb_index}, 32'd9);
        idle(2);
        check("rstw_c3_allowin", {31'd0, b_allowin}, 32'd0);
        check("rstw_c3_refetch", {31'd0, b_refetch}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstw_tlb_we", {31'd0, b_tlb_we}, 32'd0);
        check("rstw_tlb_idx", {28'd0, b_tlb_index}, 32'd0);
        check("rstw_refetch", {31'd0, b_refetch}, 32'd0);
        check("rstw_c0_pc", b_pc, 32'd0);
        check("rstw_rf_we", {28'd0, b_rf_we}, 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("rstw_after_we", {31'd0, b_tlb_we}, 32'd0);
            check("rstw_after_refetch", {31'd0, b_refetch}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
